// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared response codes, FSM state types and sizing helper for the interconnect
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_BRESP} wr_state_t;

    // A single downstream port still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4lite_addr_decoder.sv
// rtl/axi4lite_addr_decoder.sv - maps an address onto one of NUM_M equal-size regions
module axi4lite_addr_decoder #(
    parameter int                NUM_M       = 16,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                REGION_LOG2 = 6,
    parameter int                IDX_W       = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] region;

    always_comb begin
        offset = addr - BASE_ADDR;
        region = offset >> REGION_LOG2;
        hit    = (addr >= BASE_ADDR) && (region < ADDR_W'(NUM_M));
        idx    = region[IDX_W-1:0];
    end

endmodule

// File: rtl/axi4lite_interconnect_param.sv
// rtl/axi4lite_interconnect_param.sv - 1-to-NUM_M AXI4-lite router with DECERR responder and response timeout
module axi4lite_interconnect_param
    import axi4lite_pkg::*;
#(
    parameter int                NUM_M       = 16,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                REGION_LOG2 = 6,
    parameter int                TIMEOUT     = 16
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_areset,
    input  logic [ADDR_W-1:0]          s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [DATA_W-1:0]          s_axi_wdata,
    input  logic [DATA_W/8-1:0]        s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    output logic [NUM_M*ADDR_W-1:0]    m_axi_araddr,
    output logic [NUM_M-1:0]           m_axi_arvalid,
    input  logic [NUM_M-1:0]           m_axi_arready,
    input  logic [NUM_M*DATA_W-1:0]    m_axi_rdata,
    input  logic [NUM_M*2-1:0]         m_axi_rresp,
    input  logic [NUM_M-1:0]           m_axi_rvalid,
    output logic [NUM_M-1:0]           m_axi_rready,
    output logic [NUM_M*ADDR_W-1:0]    m_axi_awaddr,
    output logic [NUM_M-1:0]           m_axi_awvalid,
    input  logic [NUM_M-1:0]           m_axi_awready,
    output logic [NUM_M*DATA_W-1:0]    m_axi_wdata,
    output logic [NUM_M*DATA_W/8-1:0]  m_axi_wstrb,
    output logic [NUM_M-1:0]           m_axi_wvalid,
    input  logic [NUM_M-1:0]           m_axi_wready,
    input  logic [NUM_M*2-1:0]         m_axi_bresp,
    input  logic [NUM_M-1:0]           m_axi_bvalid,
    output logic [NUM_M-1:0]           m_axi_bready
);

    localparam int          IDX_W   = idx_width(NUM_M);
    localparam int          STRB_W  = DATA_W / 8;
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    // ---------------- read path ----------------
    rd_state_t         rd_state, rd_next;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx;
    logic [DATA_W-1:0] rd_data_q;
    logic [1:0]        rd_resp_q;
    logic [31:0]       rd_cnt;
    logic              rd_hit, rd_to;

    axi4lite_addr_decoder #(
        .NUM_M(NUM_M), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
        .REGION_LOG2(REGION_LOG2), .IDX_W(IDX_W)
    ) u_ar_dec (
        .addr(s_axi_araddr), .hit(rd_hit), .idx(rd_idx)
    );

    assign rd_to = (TIMEOUT > 0) && (rd_cnt == TO_LAST);

    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rdata   = '0;
        s_axi_rresp   = RESP_OKAY;
        m_axi_arvalid = '0;
        m_axi_araddr  = '0;
        m_axi_rready  = '0;
        if (!s_axi_areset) begin
            case (rd_state)
                R_IDLE: begin
                    s_axi_arready = 1'b1;
                    if (s_axi_arvalid) rd_next = rd_hit ? R_ADDR : R_RESP;
                end
                R_ADDR: begin
                    m_axi_arvalid[rd_idx_q]                   = 1'b1;
                    m_axi_araddr[rd_idx_q*ADDR_W +: ADDR_W]   = rd_addr_q;
                    if (m_axi_arready[rd_idx_q]) rd_next = R_DATA;
                    else if (rd_to)              rd_next = R_RESP;
                end
                R_DATA: begin
                    m_axi_rready[rd_idx_q] = 1'b1;
                    if (m_axi_rvalid[rd_idx_q] || rd_to) rd_next = R_RESP;
                end
                R_RESP: begin
                    s_axi_rvalid = 1'b1;
                    s_axi_rdata  = rd_data_q;
                    s_axi_rresp  = rd_resp_q;
                    if (s_axi_rready) rd_next = R_IDLE;
                end
                default: rd_next = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rd_state  <= R_IDLE;
            rd_addr_q <= '0;
            rd_idx_q  <= '0;
            rd_data_q <= '0;
            rd_resp_q <= RESP_OKAY;
            rd_cnt    <= '0;
        end else begin
            rd_state <= rd_next;
            rd_cnt   <= (rd_state == R_ADDR || rd_state == R_DATA) ? rd_cnt + 32'd1 : 32'd0;
            if (rd_state == R_IDLE && s_axi_arvalid) begin
                rd_addr_q <= s_axi_araddr;
                rd_idx_q  <= rd_idx;
                if (!rd_hit) begin
                    rd_data_q <= '0;
                    rd_resp_q <= RESP_DECERR;
                end
            end
            // Leaving ADDR/DATA for RESP is either a real response or a timeout.
            if ((rd_state == R_ADDR || rd_state == R_DATA) && rd_next == R_RESP) begin
                if (rd_state == R_DATA && m_axi_rvalid[rd_idx_q]) begin
                    rd_data_q <= m_axi_rdata[rd_idx_q*DATA_W +: DATA_W];
                    rd_resp_q <= m_axi_rresp[rd_idx_q*2 +: 2];
                end else begin
                    rd_data_q <= '0;
                    rd_resp_q <= RESP_SLVERR;
                end
            end
        end
    end

    // ---------------- write path ----------------
    wr_state_t         wr_state, wr_next;
    logic [ADDR_W-1:0] wr_addr_q, aw_addr_sel;
    logic [DATA_W-1:0] wr_data_q;
    logic [STRB_W-1:0] wr_strb_q;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx;
    logic [1:0]        wr_resp_q;
    logic [31:0]       wr_cnt;
    logic              wr_hit, wr_to;
    logic              aw_done, w_done, aw_sent, w_sent;
    logic              aw_hs, w_hs, aw_fin, w_fin;

    // Once AW is captured, decode the held address rather than the live bus.
    assign aw_addr_sel = aw_done ? wr_addr_q : s_axi_awaddr;

    axi4lite_addr_decoder #(
        .NUM_M(NUM_M), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
        .REGION_LOG2(REGION_LOG2), .IDX_W(IDX_W)
    ) u_aw_dec (
        .addr(aw_addr_sel), .hit(wr_hit), .idx(wr_idx)
    );

    assign wr_to  = (TIMEOUT > 0) && (wr_cnt == TO_LAST);
    assign aw_hs  = (wr_state == W_IDLE) && !aw_done && s_axi_awvalid;
    assign w_hs   = (wr_state == W_IDLE) && !w_done && s_axi_wvalid;
    assign aw_fin = aw_sent || m_axi_awready[wr_idx_q];
    assign w_fin  = w_sent || m_axi_wready[wr_idx_q];

    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        m_axi_awvalid = '0;
        m_axi_awaddr  = '0;
        m_axi_wvalid  = '0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_bready  = '0;
        if (!s_axi_areset) begin
            case (wr_state)
                W_IDLE: begin
                    s_axi_awready = !aw_done;
                    s_axi_wready  = !w_done;
                    if ((aw_done || aw_hs) && (w_done || w_hs))
                        wr_next = wr_hit ? W_ADDR : W_BRESP;
                end
                W_ADDR: begin
                    if (!aw_sent) begin
                        m_axi_awvalid[wr_idx_q]                 = 1'b1;
                        m_axi_awaddr[wr_idx_q*ADDR_W +: ADDR_W] = wr_addr_q;
                    end
                    if (!w_sent) begin
                        m_axi_wvalid[wr_idx_q]                  = 1'b1;
                        m_axi_wdata[wr_idx_q*DATA_W +: DATA_W]  = wr_data_q;
                        m_axi_wstrb[wr_idx_q*STRB_W +: STRB_W]  = wr_strb_q;
                    end
                    if (aw_fin && w_fin) wr_next = W_RESP;
                    else if (wr_to)      wr_next = W_BRESP;
                end
                W_RESP: begin
                    m_axi_bready[wr_idx_q] = 1'b1;
                    if (m_axi_bvalid[wr_idx_q] || wr_to) wr_next = W_BRESP;
                end
                W_BRESP: begin
                    s_axi_bvalid = 1'b1;
                    s_axi_bresp  = wr_resp_q;
                    if (s_axi_bready) wr_next = W_IDLE;
                end
                default: wr_next = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wr_state  <= W_IDLE;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            wr_idx_q  <= '0;
            wr_resp_q <= RESP_OKAY;
            wr_cnt    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_sent   <= 1'b0;
            w_sent    <= 1'b0;
        end else begin
            wr_state <= wr_next;
            wr_cnt   <= (wr_state == W_ADDR || wr_state == W_RESP) ? wr_cnt + 32'd1 : 32'd0;
            aw_sent  <= (wr_state == W_ADDR) && aw_fin;
            w_sent   <= (wr_state == W_ADDR) && w_fin;
            if (aw_hs) begin
                wr_addr_q <= s_axi_awaddr;
                aw_done   <= 1'b1;
            end
            if (w_hs) begin
                wr_data_q <= s_axi_wdata;
                wr_strb_q <= s_axi_wstrb;
                w_done    <= 1'b1;
            end
            if (wr_state == W_IDLE && wr_next != W_IDLE) begin
                wr_idx_q <= wr_idx;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
                if (!wr_hit) wr_resp_q <= RESP_DECERR;
            end
            if ((wr_state == W_ADDR || wr_state == W_RESP) && wr_next == W_BRESP) begin
                if (wr_state == W_RESP && m_axi_bvalid[wr_idx_q])
                    wr_resp_q <= m_axi_bresp[wr_idx_q*2 +: 2];
                else
                    wr_resp_q <= RESP_SLVERR;
            end
        end
    end

endmodule
